csla_pipe: RTL

//  Parametrised, pipelined carry-select adder: out_sum = in_a + in_b + in_cin, where in_a (WA bits) is zero-extended to W.

---
 rtl/csla_pkg.sv | 12 +
 rtl/csla_blk.sv | 36 +++
 rtl/csla_pipe.sv | 125 ++++++++++++
 3 files changed

// File: rtl/csla_pkg.sv
// Shared constants and stage-count helper for the pipelined carry-select adder.
package csla_pkg;

    localparam int CSLA_DEF_W   = 20;
    localparam int CSLA_DEF_BLK = 4;

    // Number of pipeline stages needed to cover w/blk blocks at bps blocks per stage.
    function automatic int nst(input int w, input int blk, input int bps);
        return ((w / blk) + bps - 1) / bps;
    endfunction

endpackage

// File: rtl/csla_blk.sv
// One carry-select block: plain sum and its +1 (BEC) form computed in parallel,
// the incoming carry picks one. Without an A operand the block is a pure incrementer.
module csla_blk
    import csla_pkg::*;
#(
    parameter int BLK   = CSLA_DEF_BLK,
    parameter bit HAS_A = 1'b1
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           cin,
    output logic [BLK-1:0] sum,
    output logic           cout
);

    logic [BLK-1:0] s0;
    logic [BLK-1:0] s1;
    logic           c0;
    logic           c1;

    if (HAS_A) begin : g_add
        assign {c0, s0} = {1'b0, a} + {1'b0, b};
    end else begin : g_bec
        // Above the A operand width the a inputs are tied off and never read.
        logic unused_a;
        assign unused_a = ^a;
        assign s0       = b;
        assign c0       = 1'b0;
    end

    assign s1   = s0 + BLK'(1);
    assign c1   = c0 | (&s0);
    assign sum  = cin ? s1 : s0;
    assign cout = cin ? c1 : c0;

endmodule

// File: rtl/csla_pipe.sv
// Pipelined carry-select adder: out_sum = in_a + in_b + in_cin (mod 2^W), carry on out_cout.
// Stage registers every BPS blocks, with a bubble-compressing valid/ready chain.
module csla_pipe
    import csla_pkg::*;
#(
    parameter int W   = CSLA_DEF_W,
    parameter int WA  = 16,
    parameter int BLK = CSLA_DEF_BLK,
    parameter int BPS = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WA-1:0] in_a,
    input  logic [W-1:0]  in_b,
    input  logic          in_cin,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_sum,
    output logic          out_cout
);

    localparam int NBLK = W / BLK;
    localparam int NBA  = WA / BLK;
    localparam int NST  = nst(W, BLK, BPS);

    logic [NST-1:0] vld;
    logic [NST-1:0] adv;
    logic [WA-1:0]  a_q [NST];
    logic [W-1:0]   w_q [NST];
    logic           c_q [NST];

    // A stage may load when it is empty or when the stage after it moves on,
    // so bubbles collapse while the output is stalled.
    always_comb begin
        adv        = '0;
        adv[NST-1] = ~vld[NST-1] | out_ready;
        for (int s = NST - 2; s >= 0; s--) begin
            adv[s] = ~vld[s] | adv[s+1];
        end
    end

    for (genvar s = 0; s < NST; s++) begin : g_stage
        localparam int FB = s * BPS;
        localparam int NB = (FB + BPS <= NBLK) ? BPS : NBLK - FB;

        logic [WA-1:0]  ai;
        logic [W-1:0]   wi;
        logic           vi;
        logic [NB:0]    c;
        logic [BLK-1:0] bs [NB];
        logic [W-1:0]   wn;
        logic           vr;
        logic           cr;
        logic [WA-1:0]  ar;
        logic [W-1:0]   wr;

        // The word register carries finished sum bits below this stage and raw b bits above it.
        if (s == 0) begin : g_head
            assign ai   = in_a;
            assign wi   = in_b;
            assign vi   = in_valid;
            assign c[0] = in_cin;
        end else begin : g_link
            assign ai   = a_q[s-1];
            assign wi   = w_q[s-1];
            assign vi   = vld[s-1];
            assign c[0] = c_q[s-1];
        end

        for (genvar k = 0; k < NB; k++) begin : g_blk
            localparam int J = FB + k;
            if (J < NBA) begin : g_full
                csla_blk #(.BLK(BLK), .HAS_A(1'b1)) u_blk (
                    .a   (ai[J*BLK +: BLK]),
                    .b   (wi[J*BLK +: BLK]),
                    .cin (c[k]),
                    .sum (bs[k]),
                    .cout(c[k+1])
                );
            end else begin : g_inc
                csla_blk #(.BLK(BLK), .HAS_A(1'b0)) u_blk (
                    .a   ('0),
                    .b   (wi[J*BLK +: BLK]),
                    .cin (c[k]),
                    .sum (bs[k]),
                    .cout(c[k+1])
                );
            end
        end

        always_comb begin
            wn = wi;
            for (int k = 0; k < NB; k++) begin
                wn[(FB+k)*BLK +: BLK] = bs[k];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vr <= 1'b0;
                cr <= 1'b0;
                ar <= '0;
                wr <= '0;
            end else if (adv[s]) begin
                vr <= vi;
                cr <= c[NB];
                ar <= ai;
                wr <= wn;
            end
        end

        assign vld[s] = vr;
        assign a_q[s] = ar;
        assign w_q[s] = wr;
        assign c_q[s] = cr;
    end

    assign in_ready  = adv[0];
    assign out_valid = vld[NST-1];
    assign out_sum   = w_q[NST-1];
    assign out_cout  = c_q[NST-1];

endmodule
